lab20_decoder_hold: RTL and testbench

- Registered binary-to-one-hot decoder with a valid/ready handshake and pulse stretching.
- Accepts a DATA_SIZE-bit code, for example the y/flag_valid pair produced by the team's priority/one-hot encoders.
- Drives the matching one-hot line for HOLD_CYCLES clocks, then releases it and pulses done.
- Sits on the consumer side of an encoder link: relay/LED select, or bank enable driven from a compressed index.

---
 rtl/lab20_decoder_hold.sv | 110 +++++++++++
 tb/tb_lab20_decoder_hold.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab20_decoder_hold.sv
// Registered binary-to-one-hot decoder with valid/ready handshake.
// Each accepted code drives its one-hot line for HOLD_CYCLES clocks, then pulses done.
module lab20_decoder_hold #(
  parameter int unsigned DATA_SIZE   = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_SIZE-1:0]      code,
  input  logic                      code_valid,
  output logic                      code_ready,
  input  logic                      clr,
  output logic [(2**DATA_SIZE)-1:0] y,
  output logic                      y_valid,
  output logic                      done,
  output logic [CNT_W-1:0]          accept_cnt
);

  localparam int unsigned OUT_W   = 2**DATA_SIZE;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [OUT_W-1:0]   r_y;
  logic [OUT_W-1:0]   w_y_next;
  logic               r_y_valid;
  logic               w_y_valid_next;
  logic               r_done;
  logic               w_done_next;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_done    <= 1'b0;
      r_timer   <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_y       <= w_y_next;
      r_y_valid <= w_y_valid_next;
      r_done    <= w_done_next;
      r_timer   <= w_timer_next;
      r_cnt     <= w_cnt_next;
    end
  end

  // Next-state logic; clr overrides any accept or hold expiry
  always_comb begin
    w_state_next   = r_state;
    w_y_next       = r_y;
    w_y_valid_next = r_y_valid;
    w_done_next    = 1'b0;
    w_timer_next   = r_timer;
    w_cnt_next     = r_cnt;

    if (clr) begin
      w_state_next   = S_IDLE;
      w_y_next       = '0;
      w_y_valid_next = 1'b0;
      w_timer_next   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (code_valid) begin
            w_state_next   = S_HOLD;
            w_y_next       = OUT_W'(1) << code;
            w_y_valid_next = 1'b1;
            w_timer_next   = TIMER_W'(HOLD_CYCLES - 1);
            if (!(&r_cnt)) begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (r_timer != '0) begin
            w_timer_next = r_timer - TIMER_W'(1);
          end else begin
            w_state_next   = S_IDLE;
            w_y_next       = '0;
            w_y_valid_next = 1'b0;
            w_done_next    = 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  assign code_ready = (r_state == S_IDLE);
  assign y          = r_y;
  assign y_valid    = r_y_valid;
  assign done       = r_done;
  assign accept_cnt = r_cnt;

endmodule

// File: tb/tb_lab20_decoder_hold.sv
// Bench for lab20_decoder_hold: directed vector table, hand sequences, and random traffic
// checked against an edge-count reference model on two parameterisations.
module tb_lab20_decoder_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] c0, c1;
  logic       cv0, cv1, cl0, cl1;
  logic       rdy0, rdy1;
  logic [3:0] y0, y1;
  logic       yv0, yv1, dn0, dn1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lab20_decoder_hold #(.DATA_SIZE(2), .HOLD_CYCLES(4), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .code(c0), .code_valid(cv0), .code_ready(rdy0), .clr(cl0),
    .y(y0), .y_valid(yv0), .done(dn0), .accept_cnt(cnt0)
  );

  lab20_decoder_hold #(.DATA_SIZE(2), .HOLD_CYCLES(1), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .code(c1), .code_valid(cv1), .code_ready(rdy1), .clr(cl1),
    .y(y1), .y_valid(yv1), .done(dn1), .accept_cnt(cnt1)
  );

  // Reference: remember the edge index of the last accept; outputs follow from the distance.
  typedef struct {
    bit active;
    int acc;
    int n;
    int cnt;
    int code;
  } mdl_t;

  mdl_t m0, m1;

  task automatic mstep(input mdl_t mi, input logic cv, input logic cl, input logic [1:0] cd,
                       input int h, input int cmax, output mdl_t mo);
    mdl_t m;
    bit   ready;
    m     = mi;
    ready = !(m.active && (m.n - m.acc) < h);
    m.n   = m.n + 1;
    if (cl) begin
      m.active = 1'b0;
    end else if (cv && ready) begin
      m.active = 1'b1;
      m.acc    = m.n;
      m.code   = int'(cd);
      m.cnt    = (m.cnt < cmax) ? m.cnt + 1 : cmax;
    end
    mo = m;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = '{default: 0};
      m1 = '{default: 0};
    end else begin
      mstep(m0, cv0, cl0, c0, 4, 255, m0);
      mstep(m1, cv1, cl1, c1, 1, 3, m1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input mdl_t m, input int h,
                          input logic [3:0] y, input logic yv, input logic dn,
                          input logic rdy, input logic [31:0] cnt);
    int         d;
    bit         e_yv, e_dn;
    logic [3:0] e_y;
    d    = m.n - m.acc;
    e_yv = m.active && d < h;
    e_dn = m.active && d == h;
    e_y  = e_yv ? (4'b0001 << m.code) : 4'b0000;
    chk({tag, ".y"},          32'(y),   32'(e_y));
    chk({tag, ".y_valid"},    32'(yv),  32'(e_yv));
    chk({tag, ".done"},       32'(dn),  32'(e_dn));
    chk({tag, ".code_ready"}, 32'(rdy), 32'(!e_yv));
    chk({tag, ".accept_cnt"}, cnt,      32'(m.cnt));
  endtask

  task automatic cmp_model();
    cmp_inst("main",  m0, 4, y0, yv0, dn0, rdy0, 32'(cnt0));
    cmp_inst("small", m1, 1, y1, yv1, dn1, rdy1, 32'(cnt1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic [1:0] code;
    logic       cv;
    logic       cl;
    logic [3:0] y;
    logic       yv;
    logic       dn;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];
  int   sat_exp[5];

  initial begin
    rst = 1'b1;
    {c0, c1, cv0, cv1, cl0, cl1} = '0;

    // Single accept of code 2, held 4 cycles, then done
    vt.push_back('{2'd2, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd1});
    for (int i = 0; i < 3; i++) vt.push_back('{2'd0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd1});
    vt.push_back('{2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd1});
    vt.push_back('{2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1});
    // code_valid held: 3 then 0; the change during hold is ignored
    vt.push_back('{2'd3, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd2});
    for (int i = 0; i < 3; i++) vt.push_back('{2'd0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 8'd2});
    vt.push_back('{2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd2});
    vt.push_back('{2'd0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'd3});
    for (int i = 0; i < 3; i++) vt.push_back('{2'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'd3});
    vt.push_back('{2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd3});
    // Accept code 1, clr during the hold: no done, counter untouched
    vt.push_back('{2'd1, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 8'd4});
    vt.push_back('{2'd1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 8'd4});
    vt.push_back('{2'd1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd4});
    vt.push_back('{2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd4});
    // clr with code_valid in idle: no accept
    vt.push_back('{2'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd4});
    // clr on the expiring hold cycle suppresses done
    vt.push_back('{2'd2, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd5});
    for (int i = 0; i < 3; i++) vt.push_back('{2'd0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 8'd5});
    vt.push_back('{2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd5});
    vt.push_back('{2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd5});

    // Reset state, including code_ready high while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst.y", 32'(y0), 32'd0);
    chk("rst.y_valid", 32'(yv0), 32'd0);
    chk("rst.done", 32'(dn0), 32'd0);
    chk("rst.code_ready", 32'(rdy0), 32'd1);
    chk("rst.accept_cnt", 32'(cnt0), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      c0  = vt[i].code;
      cv0 = vt[i].cv;
      cl0 = vt[i].cl;
      tick();
      chk($sformatf("vec%0d.y", i),          32'(y0),   32'(vt[i].y));
      chk($sformatf("vec%0d.y_valid", i),    32'(yv0),  32'(vt[i].yv));
      chk($sformatf("vec%0d.done", i),       32'(dn0),  32'(vt[i].dn));
      chk($sformatf("vec%0d.code_ready", i), 32'(rdy0), 32'(vt[i].rdy));
      chk($sformatf("vec%0d.accept_cnt", i), 32'(cnt0), 32'(vt[i].cnt));
    end
    {cv0, cl0} = '0;

    // Asynchronous reset between edges during a hold
    c0 = 2'd3; cv0 = 1'b1;
    tick();
    cv0 = 1'b0;
    tick();
    chk("arst.pre_y", 32'(y0), 32'b1000);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.y", 32'(y0), 32'd0);
    chk("arst.y_valid", 32'(yv0), 32'd0);
    chk("arst.accept_cnt", 32'(cnt0), 32'd0);
    chk("arst.code_ready", 32'(rdy0), 32'd1);
    rst = 1'b0;
    c0 = 2'd0; cv0 = 1'b1;
    tick();
    chk("arst.new_y", 32'(y0), 32'b0001);
    chk("arst.new_cnt", 32'(cnt0), 32'd1);
    cv0 = 1'b0;
    repeat (5) tick();

    // Saturating 2-bit counter with one-cycle holds
    sat_exp = '{1, 2, 3, 3, 3};
    cv1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c1 = 2'(k);
      tick();
      chk($sformatf("sat%0d.accept_cnt", k), 32'(cnt1), 32'(sat_exp[k]));
      chk($sformatf("sat%0d.y", k), 32'(y1), 32'(4'b0001 << k[1:0]));
      tick();
      chk($sformatf("sat%0d.y_valid_off", k), 32'(yv1), 32'd0);
      chk($sformatf("sat%0d.done", k), 32'(dn1), 32'd1);
    end
    cv1 = 1'b0;
    tick();

    // Random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      c0  = 2'($urandom);
      c1  = 2'($urandom);
      cv0 = ($urandom_range(0, 1) == 1);
      cv1 = ($urandom_range(0, 2) != 0);
      cl0 = ($urandom_range(0, 19) == 0);
      cl1 = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
